rgb_effect_pipe: RTL and testbench

- Parametrised successor to the single-effect RGB444 neighbourhood filters.
- Takes a 3x3 pixel neighbourhood and applies a runtime-selectable colour effect, then a per-channel mask, producing one output pixel.
- Effects: passthrough, gain with saturation, invert, grayscale, 3x3 box blur.
- Sits between the window/line-buffer stage and the VGA output stage. Uses a valid/ready stream with backpressure and frame-synchronous configuration.

---
 rtl/rgb_effect_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_rgb_effect_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_effect_pipe.sv
// rgb_effect_pipe: 3-stage valid/ready pixel effect pipeline over a 3x3 neighbourhood.
// Effects: pass, gain (saturating), invert, grayscale, 3x3 box blur; then per-channel mask.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_sof marks the first pixel of a frame
//   color_data           9 pixels, MSB-first: centre, L, R, U, D, UL, UR, DL, DR
//   cfg_*                shadow config write port (mode, mask, per-channel gains)
//   out_valid/out_ready  output handshake; out_sof travels with its pixel
//   filter_rgb_out       result pixel, R in MSBs, B in LSBs
module rgb_effect_pipe #(
  parameter int unsigned BPC    = 4,
  parameter int unsigned GAIN_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [27*BPC-1:0]   color_data,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_mode,
  input  logic [2:0]          cfg_mask,
  input  logic [GAIN_W-1:0]   cfg_gain_r,
  input  logic [GAIN_W-1:0]   cfg_gain_g,
  input  logic [GAIN_W-1:0]   cfg_gain_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic [3*BPC-1:0]    filter_rgb_out
);

  localparam int unsigned P  = 3 * BPC;
  localparam int unsigned SW = BPC + 4;       // 9-tap sum width
  localparam int unsigned PW = BPC + GAIN_W;  // gain product width
  localparam int unsigned BW = SW + 6;        // blur product width (57 < 2^6)
  localparam int unsigned YW = BPC + 8;       // luma accumulator width

  localparam logic [BPC-1:0]    MAX   = '1;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(16);

  localparam logic [2:0] M_GAIN = 3'd1;
  localparam logic [2:0] M_INV  = 3'd2;
  localparam logic [2:0] M_GRAY = 3'd3;
  localparam logic [2:0] M_BLUR = 3'd4;

  logic en, accept, sof_load;

  logic [2:0]              sh_mode_q, act_mode_q, sh_mask_q, act_mask_q;
  logic [2:0][GAIN_W-1:0]  sh_gain_q, act_gain_q;
  logic [2:0]              sel_mode, sel_mask;
  logic [2:0][GAIN_W-1:0]  sel_gain;
  logic [2:0][SW-1:0]      sum_d;

  logic                    v1_q, sof1_q;
  logic [P-1:0]            ctr1_q;
  logic [2:0][SW-1:0]      sum1_q;
  logic [2:0]              mode1_q, mask1_q;
  logic [2:0][GAIN_W-1:0]  gain1_q;

  logic                    v2_q, sof2_q;
  logic [2:0]              mask2_q;
  logic [P-1:0]            res2_q, res2_d;
  logic [YW-1:0]           ysum;

  logic                    v3_q, sof3_q;
  logic [P-1:0]            pix3_q, pix3_d;

  // Global stall: the whole pipe advances only when the output slot frees up.
  assign en       = ~v3_q | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign sof_load = accept & in_sof;

  // Shadow / active configuration; active swaps in only on an accepted sof beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_mode_q  <= '0;
      sh_mask_q  <= 3'b111;
      sh_gain_q  <= {3{UNITY}};
      act_mode_q <= '0;
      act_mask_q <= 3'b111;
      act_gain_q <= {3{UNITY}};
    end else begin
      if (cfg_we) begin
        sh_mode_q <= cfg_mode;
        sh_mask_q <= cfg_mask;
        sh_gain_q <= {cfg_gain_r, cfg_gain_g, cfg_gain_b};
      end
      if (sof_load) begin
        act_mode_q <= sh_mode_q;
        act_mask_q <= sh_mask_q;
        act_gain_q <= sh_gain_q;
      end
    end
  end

  // The sof pixel itself must see the config it is about to commit.
  assign sel_mode = sof_load ? sh_mode_q : act_mode_q;
  assign sel_mask = sof_load ? sh_mask_q : act_mask_q;
  assign sel_gain = sof_load ? sh_gain_q : act_gain_q;

  // Per-channel 9-tap sums; channel index 0 = B, 2 = R.
  always_comb begin
    sum_d = '0;
    for (int t = 0; t < 9; t++) begin
      for (int c = 0; c < 3; c++) begin
        sum_d[c] = sum_d[c] + SW'(color_data[t*P + c*BPC +: BPC]);
      end
    end
  end

  // Stage 1: centre pixel, sums and the pixel's own config.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      ctr1_q  <= '0;
      sum1_q  <= '0;
      mode1_q <= '0;
      mask1_q <= '0;
      gain1_q <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      sof1_q  <= in_sof & in_valid;
      ctr1_q  <= color_data[27*BPC-1 -: P];
      sum1_q  <= sum_d;
      mode1_q <= sel_mode;
      mask1_q <= sel_mask;
      gain1_q <= sel_gain;
    end
  end

  function automatic logic [BPC-1:0] sat_gain(input logic [BPC-1:0] ch,
                                               input logic [GAIN_W-1:0] g);
    logic [PW-1:0] prod;
    prod = PW'(ch) * PW'(g);
    prod = prod >> 4;
    return (prod > PW'(MAX)) ? MAX : prod[BPC-1:0];
  endfunction

  function automatic logic [BPC-1:0] sat_blur(input logic [SW-1:0] s);
    logic [BW-1:0] prod;
    prod = BW'(s) * BW'(57);
    prod = prod >> 9;
    return (prod > BW'(MAX)) ? MAX : prod[BPC-1:0];
  endfunction

  // Luma weights sum to 256, so the shifted result always fits in BPC bits.
  assign ysum = YW'(77)  * YW'(ctr1_q[P-1 -: BPC])
              + YW'(150) * YW'(ctr1_q[2*BPC-1 -: BPC])
              + YW'(29)  * YW'(ctr1_q[BPC-1:0]);

  // Stage 2: effect arithmetic; reserved modes fall through to pass.
  always_comb begin
    res2_d = ctr1_q;
    for (int c = 0; c < 3; c++) begin
      case (mode1_q)
        M_GAIN:  res2_d[c*BPC +: BPC] = sat_gain(ctr1_q[c*BPC +: BPC], gain1_q[c]);
        M_INV:   res2_d[c*BPC +: BPC] = MAX - ctr1_q[c*BPC +: BPC];
        M_GRAY:  res2_d[c*BPC +: BPC] = ysum[YW-1:8];
        M_BLUR:  res2_d[c*BPC +: BPC] = sat_blur(sum1_q[c]);
        default: res2_d[c*BPC +: BPC] = ctr1_q[c*BPC +: BPC];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q    <= 1'b0;
      sof2_q  <= 1'b0;
      mask2_q <= '0;
      res2_q  <= '0;
    end else if (en) begin
      v2_q    <= v1_q;
      sof2_q  <= sof1_q;
      mask2_q <= mask1_q;
      res2_q  <= res2_d;
    end
  end

  // Stage 3: channel mask into the output register.
  always_comb begin
    pix3_d = '0;
    for (int c = 0; c < 3; c++) begin
      if (mask2_q[c]) pix3_d[c*BPC +: BPC] = res2_q[c*BPC +: BPC];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v3_q   <= 1'b0;
      sof3_q <= 1'b0;
      pix3_q <= '0;
    end else if (en) begin
      v3_q   <= v2_q;
      sof3_q <= sof2_q;
      pix3_q <= pix3_d;
    end
  end

  assign out_valid      = v3_q;
  assign out_sof        = sof3_q;
  assign filter_rgb_out = pix3_q;

endmodule

// File: tb/tb_rgb_effect_pipe.sv
// Testbench for rgb_effect_pipe: directed cases plus randomized traffic
// checked against an arithmetic reference model and an ordered scoreboard.
module tb_rgb_effect_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_sof;
  logic [107:0] color_data;
  logic         cfg_we;
  logic [2:0]   cfg_mode, cfg_mask;
  logic [7:0]   cfg_gain_r, cfg_gain_g, cfg_gain_b;
  logic         out_valid, out_ready, out_sof;
  logic [11:0]  filter_rgb_out;

  int checks = 0;
  int errors = 0;

  // Reference config model (gain index 0 = R, 1 = G, 2 = B).
  int         sh_mode, act_mode;
  logic [2:0] sh_mask, act_mask;
  int         sh_g[3], act_g[3];
  logic [12:0] exp_q[$];
  logic [11:0] last_out;

  always #5 clk = ~clk;

  rgb_effect_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .color_data(color_data),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
    .cfg_gain_r(cfg_gain_r), .cfg_gain_g(cfg_gain_g), .cfg_gain_b(cfg_gain_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .filter_rgb_out(filter_rgb_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lim(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [11:0] ref_pix(input logic [107:0] d, input int mode,
                                          input logic [2:0] mask,
                                          input int g0, input int g1, input int g2);
    int r, g, b, y;
    int o[3];
    int s[3];
    r = int'(d[107:104]);
    g = int'(d[103:100]);
    b = int'(d[99:96]);
    s[0] = 0; s[1] = 0; s[2] = 0;
    for (int t = 0; t < 9; t++) begin
      s[0] += int'(d[12*t + 8 +: 4]);
      s[1] += int'(d[12*t + 4 +: 4]);
      s[2] += int'(d[12*t +: 4]);
    end
    case (mode)
      1: begin o[0] = lim(r * g0 / 16); o[1] = lim(g * g1 / 16); o[2] = lim(b * g2 / 16); end
      2: begin o[0] = 15 - r; o[1] = 15 - g; o[2] = 15 - b; end
      3: begin y = (77 * r + 150 * g + 29 * b) / 256; o[0] = y; o[1] = y; o[2] = y; end
      4: begin o[0] = lim(s[0] * 57 / 512); o[1] = lim(s[1] * 57 / 512); o[2] = lim(s[2] * 57 / 512); end
      default: begin o[0] = r; o[1] = g; o[2] = b; end
    endcase
    return {mask[2] ? 4'(o[0]) : 4'h0, mask[1] ? 4'(o[1]) : 4'h0, mask[0] ? 4'(o[2]) : 4'h0};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    sh_mode = 0; act_mode = 0;
    sh_mask = 3'b111; act_mask = 3'b111;
    for (int i = 0; i < 3; i++) begin sh_g[i] = 16; act_g[i] = 16; end
  endtask

  // One clock: score the handshakes seen before the edge, then check holds/reset after it.
  task automatic tick();
    logic        stalled, rst_now, hold_sof;
    logic [11:0] hold_pix;
    logic [12:0] e;
    #1;
    rst_now  = reset;
    stalled  = 1'b0;
    hold_pix = '0;
    hold_sof = 1'b0;
    if (!rst_now) begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_out observed=0x%0h expected=none", filter_rgb_out);
        end else begin
          e = exp_q.pop_front();
          chk("out_pix", 32'(filter_rgb_out), 32'(e[11:0]));
          chk("out_sof", 32'(out_sof), 32'(e[12]));
          last_out = filter_rgb_out;
        end
      end
      if (out_valid && !out_ready) begin
        stalled  = 1'b1;
        hold_pix = filter_rgb_out;
        hold_sof = out_sof;
      end
      if (in_valid && in_ready) begin
        if (in_sof) begin
          act_mode = sh_mode;
          act_mask = sh_mask;
          act_g    = sh_g;
        end
        exp_q.push_back({in_sof, ref_pix(color_data, act_mode, act_mask, act_g[0], act_g[1], act_g[2])});
      end
      if (cfg_we) begin
        sh_mode = int'(cfg_mode);
        sh_mask = cfg_mask;
        sh_g[0] = int'(cfg_gain_r);
        sh_g[1] = int'(cfg_gain_g);
        sh_g[2] = int'(cfg_gain_b);
      end
    end
    @(posedge clk);
    #1;
    if (rst_now) begin
      model_reset();
      chk("rst_out_valid", 32'(out_valid), 32'(0));
    end else if (stalled) begin
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_pix", 32'(filter_rgb_out), 32'(hold_pix));
      chk("hold_sof", 32'(out_sof), 32'(hold_sof));
    end
  endtask

  function automatic logic [107:0] nb(input logic [11:0] centre);
    logic [107:0] d;
    d = 108'({$urandom(), $urandom(), $urandom(), $urandom()});
    d[107:96] = centre;
    return d;
  endfunction

  task automatic send(input logic [107:0] d, input logic sof);
    color_data = d;
    in_sof     = sof;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    in_sof     = 1'b0;
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic set_cfg(input logic [2:0] mode, input logic [2:0] mask,
                         input logic [7:0] gr, input logic [7:0] gg, input logic [7:0] gb);
    cfg_we = 1'b1; cfg_mode = mode; cfg_mask = mask;
    cfg_gain_r = gr; cfg_gain_g = gg; cfg_gain_b = gb;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; color_data = '0;
    cfg_we = 1'b0; cfg_mode = '0; cfg_mask = '0;
    cfg_gain_r = '0; cfg_gain_g = '0; cfg_gain_b = '0;
    out_ready = 1'b1; last_out = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    chk("rst_out_sof", 32'(out_sof), 32'(0));
    chk("rst_pix", 32'(filter_rgb_out), 32'(0));
    reset = 1'b0;

    // Pass-through latency: accepting edge counts as the first of three
    color_data = nb(12'h3A5); in_sof = 1'b1; in_valid = 1'b1;
    tick();
    chk("lat_edge1", 32'(out_valid), 32'(0));
    in_valid = 1'b0; in_sof = 1'b0;
    tick();
    chk("lat_edge2", 32'(out_valid), 32'(0));
    tick();
    chk("lat_edge3", 32'(out_valid), 32'(1));
    chk("lat_pix", 32'(filter_rgb_out), 32'(12'h3A5));
    drain("drain_pass");

    set_cfg(3'd1, 3'b111, 8'h18, 8'h18, 8'h10);
    send(nb(12'hC42), 1'b1); drain("drain_gain");
    chk("gain_c42", 32'(last_out), 32'(12'hF62));

    set_cfg(3'd2, 3'b111, 8'h10, 8'h10, 8'h10);
    send(nb(12'h3A5), 1'b1); drain("drain_inv");
    chk("invert_3a5", 32'(last_out), 32'(12'hC5A));

    set_cfg(3'd3, 3'b111, 8'h10, 8'h10, 8'h10);
    send(nb(12'hF00), 1'b1); drain("drain_gray");
    chk("gray_f00", 32'(last_out), 32'(12'h444));

    set_cfg(3'd4, 3'b111, 8'h10, 8'h10, 8'h10);
    send({9{12'h80F}}, 1'b1); drain("drain_blur");
    chk("blur_80f", 32'(last_out), 32'(12'h80F));

    set_cfg(3'd0, 3'b110, 8'h10, 8'h10, 8'h10);
    send(nb(12'hFFF), 1'b1); drain("drain_mask");
    chk("mask_110", 32'(last_out), 32'(12'hFF0));

    // Mid-frame write stays pending until the next sof
    set_cfg(3'd2, 3'b111, 8'h10, 8'h10, 8'h10);
    send(nb(12'hFFF), 1'b0); drain("drain_mid_old");
    chk("midframe_old", 32'(last_out), 32'(12'hFF0));
    send(nb(12'hFFF), 1'b1); drain("drain_mid_new");
    chk("midframe_new", 32'(last_out), 32'(12'h000));

    // Write and sof on the same edge: sof takes the pre-write shadow (invert)
    cfg_we = 1'b1; cfg_mode = 3'd0; cfg_mask = 3'b111;
    send(nb(12'hFFF), 1'b1);
    cfg_we = 1'b0;
    drain("drain_same_edge");
    chk("same_edge_old", 32'(last_out), 32'(12'h000));
    send(nb(12'hFFF), 1'b1); drain("drain_same_next");
    chk("same_edge_next", 32'(last_out), 32'(12'hFFF));

    // Randomized traffic with random backpressure and config writes
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sof     = ($urandom_range(0, 7) == 0);
      color_data = nb(12'($urandom()));
      cfg_we     = ($urandom_range(0, 15) == 0);
      cfg_mode   = 3'($urandom());
      cfg_mask   = 3'($urandom());
      cfg_gain_r = 8'($urandom());
      cfg_gain_g = 8'($urandom());
      cfg_gain_b = 8'($urandom());
      out_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("drain_random");

    // Continuous input with a 5-cycle downstream stall
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      color_data = nb(12'($urandom()));
      in_sof = (i == 0);
      tick();
    end
    in_sof = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      color_data = nb(12'($urandom()));
      tick();
      chk("stall_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      color_data = nb(12'($urandom()));
      tick();
    end
    drain("drain_stall");

    // Reset while stalled discards in-flight pixels and restores config
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      color_data = nb(12'($urandom()));
      tick();
    end
    out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_idle", 32'(out_valid), 32'(0));
    send(nb(12'h3A5), 1'b1); drain("drain_post_rst");
    chk("post_rst_cfg", 32'(last_out), 32'(12'h3A5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
